// File: rtl/bounce_ctrl_pkg.sv
// bounce_ctrl_pkg: shared state encoding, default bounds and the load clamp helper.
package bounce_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, UP, DOWN, PAUSED} bc_state_t;
  localparam int BC_WIDTH = 5;
  localparam int BC_LO = 0;
  localparam int BC_HI = 25;
  function automatic int clamp(input int v, input int lo, input int hi);
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/btn_sync_edge.sv
// btn_sync_edge: 2-FF synchronizer for a raw button level with a one-cycle rising-edge pulse.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic rise
);
  logic s1, s2, s3;
  always_ff @(posedge clk)
    if (!rst_n) {s1, s2, s3} <= 3'b000;
    else {s1, s2, s3} <= {btn, s1, s2};
  assign level = s2;
  assign rise = s2 & ~s3;
endmodule

// File: rtl/bounce_count_ctrl.sv
// bounce_count_ctrl: loads a start value and bounces a bounded counter between LO and HI on tick.
// Define BOUNCE_CTRL_PAUSE_EN to build the pause button path and the PAUSED state.
module bounce_count_ctrl
  import bounce_ctrl_pkg::*;
#(
  parameter int WIDTH = BC_WIDTH,
  parameter int LO = BC_LO,
  parameter int HI = BC_HI
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             start,
  input  logic             restart,
  input  logic             pause,
  input  logic             up,
  input  logic [WIDTH-1:0] n_in,
  output logic [WIDTH-1:0] count,
  output logic             dir_up,
  output logic             running,
  output logic             paused,
  output logic             load_err
);
  localparam logic [WIDTH-1:0] LO_V = WIDTH'(LO);
  localparam logic [WIDTH-1:0] HI_V = WIDTH'(HI);
  bc_state_t state, state_d;
  logic start_p, restart_l, pause_p, load_up, load_oob, dir_d, err_d;
  logic unused_start_lvl, unused_restart_rise;
  logic [WIDTH-1:0] clamped, inc, dec, count_d;
  btn_sync_edge u_start (.clk, .rst_n, .btn(start), .level(unused_start_lvl), .rise(start_p));
  btn_sync_edge u_restart (.clk, .rst_n, .btn(restart), .level(restart_l), .rise(unused_restart_rise));
`ifdef BOUNCE_CTRL_PAUSE_EN
  logic unused_pause_lvl;
  btn_sync_edge u_pause (.clk, .rst_n, .btn(pause), .level(unused_pause_lvl), .rise(pause_p));
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign pause_p = 1'b0;
`endif
  assign clamped = WIDTH'(clamp(int'(n_in), LO, HI));
  assign load_oob = (int'(n_in) > HI) || (int'(n_in) < LO);
  // A load landing on a bound must head back into range regardless of up.
  assign load_up = clamped == HI_V ? 1'b0 : clamped == LO_V ? 1'b1 : up;
  assign inc = count + WIDTH'(1);
  assign dec = count - WIDTH'(1);
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      count <= LO_V;
      dir_up <= 1'b1;
      running <= 1'b0;
      paused <= 1'b0;
      load_err <= 1'b0;
    end else begin
      state <= state_d;
      count <= count_d;
      dir_up <= dir_d;
      running <= state_d == UP || state_d == DOWN;
      paused <= state_d == PAUSED;
      load_err <= err_d;
    end
  always_comb begin
    state_d = state;
    if (restart_l) state_d = IDLE;
    else
      case (state)
        IDLE:   state_d = start_p ? LOAD : IDLE;
        LOAD:   state_d = load_up ? UP : DOWN;
        UP:     state_d = pause_p ? PAUSED : (tick && inc == HI_V) ? DOWN : UP;
        DOWN:   state_d = pause_p ? PAUSED : (tick && dec == LO_V) ? UP : DOWN;
`ifdef BOUNCE_CTRL_PAUSE_EN
        PAUSED: state_d = pause_p ? (dir_up ? UP : DOWN) : PAUSED;
`endif
        default: state_d = IDLE;
      endcase
  end
  // Pause beats a coincident tick, so steps require no pause edge this cycle.
  always_comb begin
    count_d = restart_l ? LO_V
            : state == LOAD ? clamped
            : (state == UP && tick && !pause_p) ? inc
            : (state == DOWN && tick && !pause_p) ? dec
            : count;
    dir_d = restart_l ? 1'b1 : state_d == UP ? 1'b1 : state_d == DOWN ? 1'b0 : dir_up;
    err_d = restart_l ? 1'b0 : state == LOAD ? load_oob : load_err;
  end
endmodule

// File: tb/tb_bounce_count_ctrl.sv
// tb_bounce_count_ctrl: scoreboard-driven checks of load, bounce, clamp, restart, pause and ignored starts.
module tb_bounce_count_ctrl;
  typedef struct packed {
    logic [4:0] c;
    logic       d;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, tick = 1'b0, start = 1'b0, restart = 1'b0, pause = 1'b0, up = 1'b0;
  logic [4:0] n_in = '0;
  logic [4:0] count;
  logic dir_up, running, paused, load_err;
  exp_t sb[$];
  exp_t e;
  int checks = 0, fails = 0, m = 0;
  logic pen;
  bounce_count_ctrl #(.WIDTH(5), .LO(0), .HI(25)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .restart(restart), .pause(pause),
    .up(up), .n_in(n_in), .count(count), .dir_up(dir_up), .running(running), .paused(paused),
    .load_err(load_err)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: run still active at %0t, required finish earlier", $time);
    $fatal(1);
  end
  task automatic do_start(input logic [4:0] n, input logic u);
    n_in = n;
    up = u;
    start = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0;
  endtask
  task automatic do_restart();
    restart = 1'b1;
    repeat (3) @(negedge clk);
    restart = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  task automatic pulse_pause();
    pause = 1'b1;
    repeat (3) @(negedge clk);
    pause = 1'b0;
  endtask
  task automatic send_tick(input int c, input logic d);
    sb.push_back('{c: 5'(c), d: d});
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (count !== 5'd0 || dir_up !== 1'b1 || running !== 1'b0 || paused !== 1'b0 || load_err !== 1'b0) begin
      fails++;
      $display("FAIL reset: count=%0d dir_up=%0b running=%0b paused=%0b load_err=%0b, required 0 1 0 0 0",
               count, dir_up, running, paused, load_err);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_count();
    do_start(5, 1'b1);
    checks++;
    if (count !== 5'd5 || running !== 1'b1 || dir_up !== 1'b1) begin
      fails++;
      $display("FAIL load5: count=%0d running=%0b dir_up=%0b, required 5 1 1", count, running, dir_up);
    end
    for (int i = 6; i <= 11; i++) begin
      send_tick(i, 1'b1);
      e = sb.pop_front();
      checks++;
      if (count !== e.c || dir_up !== e.d) begin
        fails++;
        $display("FAIL count_up: count=%0d dir_up=%0b, required %0d %0b", count, dir_up, e.c, e.d);
      end
    end
  endtask
  task automatic test_bounce();
    int seq[4] = '{24, 25, 24, 23};
    do_restart();
    do_start(23, 1'b1);
    checks++;
    if (count !== 5'd23 || dir_up !== 1'b1) begin
      fails++;
      $display("FAIL load23: count=%0d dir_up=%0b, required 23 1", count, dir_up);
    end
    for (int i = 0; i < 4; i++) begin
      send_tick(seq[i], i == 0);
      e = sb.pop_front();
      checks++;
      if (count !== e.c || dir_up !== e.d) begin
        fails++;
        $display("FAIL bounce_hi: count=%0d dir_up=%0b, required %0d %0b", count, dir_up, e.c, e.d);
      end
    end
  endtask
  task automatic test_clamp();
    do_restart();
    do_start(0, 1'b0);
    checks++;
    if (count !== 5'd0 || dir_up !== 1'b1 || load_err !== 1'b0) begin
      fails++;
      $display("FAIL load_lo: count=%0d dir_up=%0b load_err=%0b, required 0 1 0", count, dir_up, load_err);
    end
    for (int i = 1; i <= 2; i++) begin
      send_tick(i, 1'b1);
      e = sb.pop_front();
      checks++;
      if (count !== e.c || dir_up !== e.d) begin
        fails++;
        $display("FAIL from_lo: count=%0d dir_up=%0b, required %0d %0b", count, dir_up, e.c, e.d);
      end
    end
    do_restart();
    do_start(30, 1'b1);
    checks++;
    if (count !== 5'd25 || dir_up !== 1'b0 || load_err !== 1'b1) begin
      fails++;
      $display("FAIL clamp_hi: count=%0d dir_up=%0b load_err=%0b, required 25 0 1", count, dir_up, load_err);
    end
    send_tick(24, 1'b0);
    e = sb.pop_front();
    checks++;
    if (count !== e.c || dir_up !== e.d || load_err !== 1'b1) begin
      fails++;
      $display("FAIL after_clamp: count=%0d dir_up=%0b load_err=%0b, required %0d %0b 1",
               count, dir_up, load_err, e.c, e.d);
    end
  endtask
  task automatic test_restart();
    do_restart();
    do_start(30, 1'b1);
    for (int i = 24; i >= 17; i--) begin
      send_tick(i, 1'b0);
      e = sb.pop_front();
      checks++;
      if (count !== e.c || dir_up !== e.d) begin
        fails++;
        $display("FAIL count_down: count=%0d dir_up=%0b, required %0d %0b", count, dir_up, e.c, e.d);
      end
    end
    restart = 1'b1;
    repeat (2) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    checks++;
    if (count !== 5'd0 || dir_up !== 1'b1 || load_err !== 1'b0 || running !== 1'b0) begin
      fails++;
      $display("FAIL restart: count=%0d dir_up=%0b load_err=%0b running=%0b, required 0 1 0 0",
               count, dir_up, load_err, running);
    end
    restart = 1'b0;
    repeat (3) @(negedge clk);
    send_tick(0, 1'b1);
    e = sb.pop_front();
    checks++;
    if (count !== e.c || dir_up !== e.d) begin
      fails++;
      $display("FAIL idle_tick: count=%0d dir_up=%0b, required %0d %0b", count, dir_up, e.c, e.d);
    end
  endtask
  task automatic test_pause();
    do_start(11, 1'b1);
    send_tick(12, 1'b1);
    e = sb.pop_front();
    m = 12;
    pulse_pause();
    checks++;
    if (paused !== pen || running !== !pen) begin
      fails++;
      $display("FAIL pause_on: paused=%0b running=%0b, required %0b %0b", paused, running, pen, !pen);
    end
    for (int i = 0; i < 5; i++) begin
      m = pen ? m : m + 1;
      send_tick(m, 1'b1);
      e = sb.pop_front();
      checks++;
      if (count !== e.c || dir_up !== e.d) begin
        fails++;
        $display("FAIL paused_tick: count=%0d dir_up=%0b, required %0d %0b", count, dir_up, e.c, e.d);
      end
    end
    pulse_pause();
    checks++;
    if (paused !== 1'b0 || running !== 1'b1) begin
      fails++;
      $display("FAIL pause_off: paused=%0b running=%0b, required 0 1", paused, running);
    end
    m++;
    send_tick(m, 1'b1);
    e = sb.pop_front();
    checks++;
    if (count !== e.c || dir_up !== e.d) begin
      fails++;
      $display("FAIL resume_tick: count=%0d dir_up=%0b, required %0d %0b", count, dir_up, e.c, e.d);
    end
    repeat (3) @(negedge clk);
  endtask
  task automatic test_start_during_run();
    do_start(3, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (count !== 5'(m) || running !== 1'b1 || dir_up !== 1'b1) begin
      fails++;
      $display("FAIL no_reload: count=%0d running=%0b dir_up=%0b, required %0d 1 1", count, running, dir_up, m);
    end
    m++;
    send_tick(m, 1'b1);
    e = sb.pop_front();
    checks++;
    if (count !== e.c || dir_up !== e.d) begin
      fails++;
      $display("FAIL run_on: count=%0d dir_up=%0b, required %0d %0b", count, dir_up, e.c, e.d);
    end
  endtask
  task automatic test_back_to_back();
    tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m++;
      sb.push_back('{c: 5'(m), d: 1'b1});
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (count !== e.c || dir_up !== e.d) begin
        fails++;
        $display("FAIL b2b_tick: count=%0d dir_up=%0b, required %0d %0b", count, dir_up, e.c, e.d);
      end
    end
    tick = 1'b0;
  endtask
  initial begin
`ifdef BOUNCE_CTRL_PAUSE_EN
    pen = 1'b1;
`else
    pen = 1'b0;
`endif
    test_reset();
    test_count();
    test_bounce();
    test_clamp();
    test_restart();
    test_pause();
    test_start_during_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
